tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of software-timer channels (1..4).
REQ-002 SHALL have parameter TICK_W, default 32, tick-counter width.
REQ-003 SHALL have port clk  input  1  system clock; the block has one clock.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port tmr_address  output  3  word address to the interval-timer slave.
REQ-006 SHALL have port tmr_chipselect  output  1  timer slave select.
REQ-007 SHALL have port tmr_write_n  output  1  timer write strobe, active-low.
REQ-008 SHALL have port tmr_writedata  output  16  timer write data.
REQ-009 SHALL have port tmr_irq  input  1  timer timeout interrupt.
REQ-010 SHALL have port cfg_address  input  4  CPU slave word address.
REQ-011 SHALL have port cfg_chipselect  input  1  CPU slave select.
REQ-012 SHALL have port cfg_write_n  input  1  CPU write strobe, active-low.
REQ-013 SHALL have port cfg_writedata  input  32  CPU write data.
REQ-014 SHALL have port cfg_readdata  output  32  CPU read data, registered.
REQ-015 SHALL have port expire  output  NUM_CH  per-channel expiry flags.
REQ-016 SHALL have port sched_irq  output  1  OR of (expire & irq_mask).

Function
REQ-017 FSM states SHALL be INIT, ENABLE, IDLE, CLEAR, UPDATE.
REQ-018 INIT SHALL last 1 cycle with no timer access, then go to ENABLE.
REQ-019 ENABLE SHALL drive chipselect=1, write_n=0, address=1, writedata=16'h0001 for 1 cycle, then go to IDLE.
REQ-020 IDLE with tmr_irq=1 SHALL go to CLEAR; otherwise it SHALL stay in IDLE with chipselect=0, write_n=1.
REQ-021 CLEAR SHALL write address=0, data=0 (status clear) for 1 cycle, then go to UPDATE.
REQ-022 UPDATE SHALL last 1 cycle, then go to IDLE; tmr_irq sampled in UPDATE SHALL be ignored.
REQ-023 In UPDATE with ctrl.run=1, tick_cnt SHALL increment modulo 2^TICK_W; with run=0 the timer is still cleared and tick_cnt holds.
REQ-024 Channel expiry SHALL occur in UPDATE when armed[i]=1 and the incremented tick_cnt equals deadline[i]: expire[i] is set and armed[i] is cleared.
REQ-025 Address map SHALL be:
- 0: tick_cnt (RW; write loads the value)
- 1: expire (W1C)
- 2: irq_mask
- 3: ctrl (bit0 run)
- 4+i: deadline[i] (write also sets armed[i])
- 8+i: period[i]
- bit i of reads at 12: armed
- unmapped or unused-channel addresses: read 0, ignore writes
REQ-026 cfg_readdata SHALL be valid the cycle after the chipselect cycle (1-cycle latency).
REQ-027 When a W1C clear and a new expiry hit the same bit in the same cycle, the set SHALL win.
REQ-028 When a deadline write coincides with a matching UPDATE on the same channel, the write SHALL win: the channel is armed with the new value and does not expire.
REQ-029 When a CPU tick_cnt write coincides with UPDATE, the CPU value SHALL be loaded and the increment dropped.
REQ-030 sched_irq SHALL be combinational from the registered expire and irq_mask.

Reset
REQ-031 On reset_n=0 at a clk edge:
- state SHALL go to INIT
- tick_cnt, expire, irq_mask, armed, deadline, period and cfg_readdata SHALL go to 0
- ctrl.run SHALL go to 1
- tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0
REQ-032 Reset asserted mid-sequence (ENABLE, CLEAR or UPDATE) SHALL abort the sequence; INIT→ENABLE SHALL re-execute after release.

Configuration
REQ-033 With TICK_SCHED_AUTORELOAD_EN defined, an expiry on a channel with period[i]≠0 SHALL set expire[i], keep armed[i]=1 and set deadline[i] to deadline[i]+period[i] (modulo); period[i]=0 behaves one-shot.
REQ-034 Without TICK_SCHED_AUTORELOAD_EN, period registers SHALL NOT exist, addresses 8+i SHALL read 0, and all channels SHALL be one-shot.

Structure
REQ-035 A shared package SHALL hold:
- the FSM state enum
- cfg address constants
- timer register address constants (STATUS=0, CONTROL=1)
- the ITO control value 16'h0001
REQ-036 A sub-module tick_sched_channel SHALL hold deadline, period, armed and the compare/reload logic, and SHALL be instantiated NUM_CH times.

Verification
REQ-037 Release reset → ENABLE write (addr 1, data 1) exactly 2 cycles after release; then no timer access while tmr_irq=0.
REQ-038 Pulse tmr_irq 3 times → 3 CLEAR writes to addr 0; tick_cnt reads 3.
REQ-039 Write deadline[0]=5, irq_mask=1, then 5 ticks → expire[0]=1 and sched_irq=1 after the 5th UPDATE; W1C of 1 clears both; armed[0]=0.
REQ-040 Load tick_cnt=32'hFFFFFFFF, deadline[1]=0, then 1 tick → tick_cnt=0 and expire[1]=1.
REQ-041 With the macro, deadline[2]=2 and period[2]=3, then 8 ticks → expire[2] sets at ticks 2, 5 and 8.
REQ-042 Issue a W1C of expire[0] in the same cycle as a new expiry of channel 0 → expire[0] stays 1; assert reset during CLEAR → INIT followed by ENABLE.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared constants for the tick scheduler: FSM states, CPU register map and interval-timer registers.
// Optional feature macro: TICK_SCHED_AUTORELOAD_EN (periodic channels).
package tick_sched_pkg;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_ENABLE = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_CLEAR  = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;

    localparam logic [3:0] CFG_TICK      = 4'd0;
    localparam logic [3:0] CFG_EXPIRE    = 4'd1;
    localparam logic [3:0] CFG_MASK      = 4'd2;
    localparam logic [3:0] CFG_CTRL      = 4'd3;
    localparam logic [3:0] CFG_DEADLINE0 = 4'd4;
    localparam logic [3:0] CFG_PERIOD0   = 4'd8;
    localparam logic [3:0] CFG_ARMED     = 4'd12;

    localparam logic [2:0]  TMR_STATUS   = 3'd0;
    localparam logic [2:0]  TMR_CONTROL  = 3'd1;
    localparam logic [15:0] TMR_CTRL_ITO = 16'h0001;

    function automatic logic [3:0] ch_addr(input logic [3:0] base, input int unsigned ch);
        return base + 4'(ch);
    endfunction

endpackage

// File: rtl/tick_sched_channel.sv
// One software-timer channel: deadline/period storage, arm flag and the compare/reload decision.
// Optional feature macro: TICK_SCHED_AUTORELOAD_EN (periodic reload instead of one-shot).
module tick_sched_channel
    import tick_sched_pkg::*;
#(
    parameter int TICK_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              upd_en,
    input  logic [TICK_W-1:0] tick_next,
    input  logic              dl_we,
    input  logic              pd_we,
    input  logic [TICK_W-1:0] wdata,
    output logic [TICK_W-1:0] deadline,
    output logic [TICK_W-1:0] period,
    output logic              armed,
    output logic              hit
);

    logic [TICK_W-1:0] deadline_q, deadline_d;
    logic              armed_q, armed_d;
    logic [TICK_W-1:0] period_q, period_d;

    // A deadline write on the same cycle as a match re-arms instead of expiring.
    assign hit = upd_en & armed_q & (tick_next == deadline_q) & ~dl_we;

    // Next-state for deadline, period and arm flag.
    always_comb begin
        deadline_d = deadline_q;
        armed_d    = armed_q;
        if (dl_we) begin
            deadline_d = wdata;
            armed_d    = 1'b1;
        end else if (hit) begin
`ifdef TICK_SCHED_AUTORELOAD_EN
            if (period_q != '0) begin
                deadline_d = deadline_q + period_q;
                armed_d    = 1'b1;
            end else begin
                armed_d    = 1'b0;
            end
`else
            armed_d = 1'b0;
`endif
        end else begin
            armed_d = armed_q;
        end
`ifdef TICK_SCHED_AUTORELOAD_EN
        period_d = pd_we ? wdata : period_q;
`else
        period_d = '0;
`endif
    end

`ifndef TICK_SCHED_AUTORELOAD_EN
    logic unused_pd_we_s;
    assign unused_pd_we_s = pd_we;
`endif

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deadline_q <= '0;
            period_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            deadline_q <= deadline_d;
            period_q   <= period_d;
            armed_q    <= armed_d;
        end
    end

    assign deadline = deadline_q;
    assign period   = period_q;
    assign armed    = armed_q;

endmodule

// File: rtl/tick_scheduler.sv
// Tick scheduler: acknowledges interval-timer interrupts, keeps a tick count and NUM_CH deadline channels.
// Optional feature macro: TICK_SCHED_AUTORELOAD_EN (periodic channels via period registers).
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int TICK_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic              tmr_irq,
    input  logic [3:0]        cfg_address,
    input  logic              cfg_chipselect,
    input  logic              cfg_write_n,
    input  logic [31:0]       cfg_writedata,
    output logic [31:0]       cfg_readdata,
    output logic [NUM_CH-1:0] expire,
    output logic              sched_irq
);

    logic [2:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d, tick_next_s;
    logic [NUM_CH-1:0] expire_q, expire_d, irq_mask_q, irq_mask_d;
    logic [NUM_CH-1:0] hit_s, armed_s, dl_we_s, pd_we_s, w1c_s;
    logic              run_q, run_d;
    logic [31:0]       cfg_readdata_q, cfg_readdata_d, rd_s, rd_ch_s;
    logic              tmr_cs_q, tmr_cs_d, tmr_wn_q, tmr_wn_d;
    logic [2:0]        tmr_addr_q, tmr_addr_d;
    logic [15:0]       tmr_data_q, tmr_data_d;
    logic              cfg_wr_s, cfg_rd_s, upd_en_s;
    logic [TICK_W-1:0] dl_s [NUM_CH];
    logic [TICK_W-1:0] pd_s [NUM_CH];

    assign cfg_wr_s    = cfg_chipselect & ~cfg_write_n;
    assign cfg_rd_s    = cfg_chipselect & cfg_write_n;
    assign upd_en_s    = (state_q == ST_UPDATE) & run_q;
    assign tick_next_s = tick_cnt_q + TICK_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign dl_we_s[i] = cfg_wr_s & (cfg_address == ch_addr(CFG_DEADLINE0, i));
        assign pd_we_s[i] = cfg_wr_s & (cfg_address == ch_addr(CFG_PERIOD0, i));
        tick_sched_channel #(.TICK_W(TICK_W)) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .upd_en   (upd_en_s),
            .tick_next(tick_next_s),
            .dl_we    (dl_we_s[i]),
            .pd_we    (pd_we_s[i]),
            .wdata    (TICK_W'(cfg_writedata)),
            .deadline (dl_s[i]),
            .period   (pd_s[i]),
            .armed    (armed_s[i]),
            .hit      (hit_s[i])
        );
    end

    // Timer-handshake FSM; bus values are registered, so they trail the state by one cycle.
    always_comb begin
        state_d    = state_q;
        tmr_cs_d   = 1'b0;
        tmr_wn_d   = 1'b1;
        tmr_addr_d = 3'd0;
        tmr_data_d = 16'h0000;
        case (state_q)
            ST_INIT:   state_d = ST_ENABLE;
            ST_ENABLE: begin
                state_d    = ST_IDLE;
                tmr_cs_d   = 1'b1;
                tmr_wn_d   = 1'b0;
                tmr_addr_d = TMR_CONTROL;
                tmr_data_d = TMR_CTRL_ITO;
            end
            ST_IDLE:   state_d = tmr_irq ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: begin
                state_d    = ST_UPDATE;
                tmr_cs_d   = 1'b1;
                tmr_wn_d   = 1'b0;
                tmr_addr_d = TMR_STATUS;
                tmr_data_d = 16'h0000;
            end
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_INIT;
        endcase
    end

    // Register-file next state; a CPU tick load beats the increment and a new expiry beats W1C.
    always_comb begin
        if (cfg_wr_s && (cfg_address == CFG_TICK)) begin
            tick_cnt_d = TICK_W'(cfg_writedata);
        end else if (upd_en_s) begin
            tick_cnt_d = tick_next_s;
        end else begin
            tick_cnt_d = tick_cnt_q;
        end
        w1c_s      = (cfg_wr_s && (cfg_address == CFG_EXPIRE)) ? cfg_writedata[NUM_CH-1:0] : '0;
        expire_d   = (expire_q & ~w1c_s) | hit_s;
        irq_mask_d = (cfg_wr_s && (cfg_address == CFG_MASK)) ? cfg_writedata[NUM_CH-1:0] : irq_mask_q;
        run_d      = (cfg_wr_s && (cfg_address == CFG_CTRL)) ? cfg_writedata[0] : run_q;
    end

    // CPU read mux; unmapped and absent-channel addresses return zero.
    always_comb begin
        rd_ch_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_ch_s = rd_ch_s
                    | ((cfg_address == ch_addr(CFG_DEADLINE0, i)) ? 32'(dl_s[i]) : 32'd0)
                    | ((cfg_address == ch_addr(CFG_PERIOD0, i))   ? 32'(pd_s[i]) : 32'd0);
        end
        case (cfg_address)
            CFG_TICK:   rd_s = 32'(tick_cnt_q);
            CFG_EXPIRE: rd_s = 32'(expire_q);
            CFG_MASK:   rd_s = 32'(irq_mask_q);
            CFG_CTRL:   rd_s = {31'd0, run_q};
            CFG_ARMED:  rd_s = 32'(armed_s);
            default:    rd_s = rd_ch_s;
        endcase
        cfg_readdata_d = cfg_rd_s ? rd_s : cfg_readdata_q;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_INIT;
            tick_cnt_q     <= '0;
            expire_q       <= '0;
            irq_mask_q     <= '0;
            run_q          <= 1'b1;
            cfg_readdata_q <= 32'd0;
            tmr_cs_q       <= 1'b0;
            tmr_wn_q       <= 1'b1;
            tmr_addr_q     <= 3'd0;
            tmr_data_q     <= 16'h0000;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            expire_q       <= expire_d;
            irq_mask_q     <= irq_mask_d;
            run_q          <= run_d;
            cfg_readdata_q <= cfg_readdata_d;
            tmr_cs_q       <= tmr_cs_d;
            tmr_wn_q       <= tmr_wn_d;
            tmr_addr_q     <= tmr_addr_d;
            tmr_data_q     <= tmr_data_d;
        end
    end

    assign tmr_chipselect = tmr_cs_q;
    assign tmr_write_n    = tmr_wn_q;
    assign tmr_address    = tmr_addr_q;
    assign tmr_writedata  = tmr_data_q;
    assign cfg_readdata   = cfg_readdata_q;
    assign expire         = expire_q;
    assign sched_irq      = |(expire_q & irq_mask_q);

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: register-level reference model plus directed scenarios.
// Periodic-channel scenario runs only when TICK_SCHED_AUTORELOAD_EN is defined.
module tb_tick_scheduler;

    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect, tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq = 1'b0;
    logic [3:0]  cfg_address = 4'd0;
    logic        cfg_chipselect = 1'b0;
    logic        cfg_write_n = 1'b1;
    logic [31:0] cfg_writedata = 32'd0;
    logic [31:0] cfg_readdata;
    logic [NUM_CH-1:0] expire;
    logic        sched_irq;

    always #5 clk = ~clk;

    tick_scheduler #(.NUM_CH(NUM_CH), .TICK_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_irq(tmr_irq),
        .cfg_address(cfg_address), .cfg_chipselect(cfg_chipselect),
        .cfg_write_n(cfg_write_n), .cfg_writedata(cfg_writedata),
        .cfg_readdata(cfg_readdata), .expire(expire), .sched_irq(sched_irq)
    );

    int n_checks = 0;
    int n_pass = 0;
    int clr_cnt = 0, en_cnt = 0, bad_cnt = 0;
    bit chk_en = 1'b0;
    logic [31:0] rv;

    // Reference model of the programmer-visible registers.
    logic [31:0] m_tick;
    logic [31:0] m_dl [NUM_CH];
    logic [31:0] m_pd [NUM_CH];
    logic [3:0]  m_exp, m_mask, m_armed;
    logic        m_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic model_reset();
        m_tick = 32'd0; m_exp = 4'd0; m_mask = 4'd0; m_armed = 4'd0; m_run = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin m_dl[i] = 32'd0; m_pd[i] = 32'd0; end
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        if (a == 4'd0) m_tick = d;
        else if (a == 4'd1) m_exp = m_exp & ~d[3:0];
        else if (a == 4'd2) m_mask = d[3:0];
        else if (a == 4'd3) m_run = d[0];
        else if (a >= 4'd4 && a <= 4'd7) begin m_dl[a[1:0]] = d; m_armed[a[1:0]] = 1'b1; end
`ifdef TICK_SCHED_AUTORELOAD_EN
        else if (a >= 4'd8 && a <= 4'd11) m_pd[a[1:0]] = d;
`endif
    endtask

    // One timer tick, optionally with a CPU write landing on the same cycle.
    task automatic model_tick(input bit has_wr, input logic [3:0] a, input logic [31:0] d);
        logic [31:0] nt;
        logic [3:0]  hits;
        nt = m_run ? m_tick + 32'd1 : m_tick;
        hits = 4'd0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_run && m_armed[i] && nt == m_dl[i] && !(has_wr && a == 4'(4 + i))) hits[i] = 1'b1;
        m_tick = nt;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hits[i]) begin
`ifdef TICK_SCHED_AUTORELOAD_EN
                if (m_pd[i] != 32'd0) m_dl[i] = m_dl[i] + m_pd[i];
                else m_armed[i] = 1'b0;
`else
                m_armed[i] = 1'b0;
`endif
            end
        end
        if (has_wr) model_write(a, d);
        m_exp = m_exp | hits;
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
        if (a == 4'd0) return m_tick;
        if (a == 4'd1) return {28'd0, m_exp};
        if (a == 4'd2) return {28'd0, m_mask};
        if (a == 4'd3) return {31'd0, m_run};
        if (a >= 4'd4 && a <= 4'd7) return m_dl[a[1:0]];
        if (a >= 4'd8 && a <= 4'd11) return m_pd[a[1:0]];
        if (a == 4'd12) return {28'd0, m_armed};
        return 32'd0;
    endfunction

    task automatic cpu_wr(input logic [3:0] a, input logic [31:0] d);
        cfg_address = a; cfg_writedata = d; cfg_chipselect = 1'b1; cfg_write_n = 1'b0;
        @(posedge clk);
        model_write(a, d);
        @(negedge clk);
        cfg_chipselect = 1'b0; cfg_write_n = 1'b1;
    endtask

    task automatic cpu_rd(input string name, input logic [3:0] a, output logic [31:0] v);
        cfg_address = a; cfg_chipselect = 1'b1; cfg_write_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_chipselect = 1'b0;
        v = cfg_readdata;
        check(name, v, mread(a));
    endtask

    // Acts as the interval timer: raise irq, drop it once the status clear is on the bus.
    task automatic tick_op(input bit has_wr, input logic [3:0] a, input logic [31:0] d);
        bit seen;
        seen = 1'b0;
        tmr_irq = 1'b1;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) seen = 1'b1;
        end
        tmr_irq = 1'b0;
        if (!seen) check("tick_clear_timeout", 32'd0, 32'd1);
        if (has_wr) begin
            cfg_address = a; cfg_writedata = d; cfg_chipselect = 1'b1; cfg_write_n = 1'b0;
        end
        @(posedge clk);
        if (seen) model_tick(has_wr, a, d);
        else if (has_wr) model_write(a, d);
        @(negedge clk);
        cfg_chipselect = 1'b0; cfg_write_n = 1'b1;
    endtask

    // Called at the negedge where reset_n was just released.
    task automatic check_enable_seq(input string tag);
        @(negedge clk);
        check({tag, "_init_quiet"}, {31'd0, tmr_chipselect}, 32'd0);
        @(negedge clk);
        check({tag, "_enable_write"}, 32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
              32'({1'b1, 1'b0, 3'd1, 16'h0001}));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_idle_quiet"}, {31'd0, tmr_chipselect}, 32'd0);
        end
    endtask

    // Timer-bus monitor.
    always @(negedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            if (tmr_address == 3'd0 && tmr_writedata == 16'h0000) clr_cnt++;
            else if (tmr_address == 3'd1 && tmr_writedata == 16'h0001) en_cnt++;
            else bad_cnt++;
        end
    end

    // Per-cycle comparison of expiry flags and interrupt against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("expire", {28'd0, expire}, {28'd0, m_exp});
            check("sched_irq", {31'd0, sched_irq}, {31'd0, |(m_exp & m_mask)});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readdata", cfg_readdata, 32'd0);
        check("rst_tmr_bus", 32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
              32'({1'b0, 1'b1, 3'd0, 16'h0000}));
        check("rst_expire", {28'd0, expire}, 32'd0);
        chk_en = 1'b1;
        reset_n = 1'b1;
        check_enable_seq("boot");

        // Three timer interrupts.
        for (int k = 0; k < 3; k++) tick_op(1'b0, 4'd0, 32'd0);
        #1 check("clear_writes", clr_cnt, 32'd3);
        @(negedge clk);
        cpu_rd("rd_tick3", 4'd0, rv);
        check("tick_is_3", rv, 32'd3);

        // One-shot channel 0 at tick 5 with interrupt mask.
        cpu_wr(4'd0, 32'd0);
        cpu_wr(4'd4, 32'd5);
        cpu_wr(4'd2, 32'd1);
        for (int k = 0; k < 5; k++) tick_op(1'b0, 4'd0, 32'd0);
        check("exp0_set", {28'd0, expire}, 32'd1);
        check("irq_set", {31'd0, sched_irq}, 32'd1);
        cpu_wr(4'd1, 32'd1);
        check("exp0_w1c", {28'd0, expire}, 32'd0);
        check("irq_w1c", {31'd0, sched_irq}, 32'd0);
        cpu_rd("rd_armed", 4'd12, rv);
        check("armed0_clear", rv & 32'd1, 32'd0);

        // Tick counter wrap onto deadline 0.
        cpu_wr(4'd0, 32'hFFFF_FFFF);
        cpu_wr(4'd5, 32'd0);
        tick_op(1'b0, 4'd0, 32'd0);
        cpu_rd("rd_wrap", 4'd0, rv);
        check("tick_wrap", rv, 32'd0);
        check("exp1_wrap", {28'd0, expire}, 32'd2);
        cpu_wr(4'd1, 32'd2);

        // W1C colliding with a fresh expiry: the set must survive.
        cpu_wr(4'd4, 32'd1);
        tick_op(1'b0, 4'd0, 32'd0);
        cpu_wr(4'd4, 32'd2);
        tick_op(1'b1, 4'd1, 32'd1);
        check("w1c_vs_set", {28'd0, expire}, 32'd1);
        cpu_wr(4'd1, 32'd1);

        // Deadline write colliding with a match: re-armed, no expiry.
        cpu_wr(4'd5, 32'd3);
        tick_op(1'b1, 4'd5, 32'd10);
        check("dlwr_no_exp", {28'd0, expire}, 32'd0);
        cpu_rd("rd_dl1", 4'd5, rv);
        check("dl1_new", rv, 32'd10);
        cpu_rd("rd_armed2", 4'd12, rv);
        check("armed1_set", rv, 32'd2);

        // CPU tick load colliding with an increment.
        tick_op(1'b1, 4'd0, 32'd100);
        cpu_rd("rd_tickld", 4'd0, rv);
        check("tick_load_wins", rv, 32'd100);

        // Stopped counter: timer still acknowledged, count holds.
        cpu_wr(4'd3, 32'd0);
        c0 = clr_cnt;
        tick_op(1'b0, 4'd0, 32'd0);
        check("stopped_clear", clr_cnt, c0 + 1);
        cpu_rd("rd_stopped", 4'd0, rv);
        check("tick_held", rv, 32'd100);
        cpu_wr(4'd3, 32'd1);

`ifdef TICK_SCHED_AUTORELOAD_EN
        cpu_wr(4'd0, 32'd0);
        cpu_wr(4'd10, 32'd3);
        cpu_wr(4'd6, 32'd2);
        for (int k = 1; k <= 8; k++) begin
            tick_op(1'b0, 4'd0, 32'd0);
            check($sformatf("reload_t%0d", k), {31'd0, expire[2]},
                  (k == 2 || k == 5 || k == 8) ? 32'd1 : 32'd0);
            if (expire[2]) cpu_wr(4'd1, 32'd4);
        end
`else
        cpu_wr(4'd8, 32'd7);
        cpu_rd("rd_period", 4'd8, rv);
        check("no_period", rv, 32'd0);
`endif
        cpu_wr(4'd15, 32'hDEAD_BEEF);
        cpu_rd("rd_unmapped", 4'd15, rv);
        check("unmapped_zero", rv, 32'd0);

        // Reset while in CLEAR aborts the status write and restarts the handshake.
        c0 = clr_cnt;
        tmr_irq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        tmr_irq = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check("abort_no_clear", {31'd0, tmr_chipselect}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_enable_seq("rerun");
        check("abort_clear_cnt", clr_cnt, c0);
        cpu_rd("rd_tick_rst", 4'd0, rv);
        check("tick_rst", rv, 32'd0);
        cpu_rd("rd_ctrl_rst", 4'd3, rv);
        check("run_rst", rv, 32'd1);
        check("enable_writes", en_cnt, 32'd2);
        check("bad_tmr_writes", bad_cnt, 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
